dmem_arbiter: RTL and testbench

Two-port arbiter and sequencer placed in front of the single-port `data_memory`. It shares the memory between requester 0 (core load/store unit) and requester 1 (debug/loader port). Sharing uses round-robin arbitration with an optional bounded lock for back-to-back bursts. Each accepted request is driven to the memory in the same cycle, and the read response is returned on a registered, per-port response channel one cycle later.

---
 rtl/dmem_arbiter.sv | 157 +++++++++++++++
 tb/tb_dmem_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port data_memory between the core LSU (port 0)
// and the debug/loader port (port 1). Round-robin arbitration with a bounded
// lock for bursts; reads return on a registered per-port channel one cycle
// after acceptance.
module dmem_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 10,
    parameter int LOCK_MAX   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            req_valid,
    output logic [1:0]            req_ready,
    input  logic [1:0]            req_write,
    input  logic [1:0]            req_lock,
    input  logic [ADDR_WIDTH-1:0] req_addr0,
    input  logic [ADDR_WIDTH-1:0] req_addr1,
    input  logic [DATA_WIDTH-1:0] req_wdata0,
    input  logic [DATA_WIDTH-1:0] req_wdata1,
    output logic [1:0]            resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata0,
    output logic [DATA_WIDTH-1:0] resp_rdata1,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic                  mem_write,
    output logic                  mem_read,
    input  logic [DATA_WIDTH-1:0] mem_read_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    // Lock counter value reached on the final beat a locked owner may take.
    localparam logic [3:0] LAST_CNT = 4'(LOCK_MAX - 1);

    state_t     state;
    state_t     state_next;
    logic       rr_ptr;
    logic       rr_next;
    logic [3:0] lock_cnt;
    logic [3:0] lock_cnt_next;

    logic [1:0] grant;
    logic       accept;
    logic       gport;
    logic       gwrite;
    logic       glock;

    // Grant selection: at most one port, never while reset is asserted.
    always_comb begin
        grant = 2'b00;
        if (!reset) begin
            case (state)
                IDLE: begin
                    if (req_valid == 2'b11) begin
                        grant = rr_ptr ? 2'b10 : 2'b01;
                    end else begin
                        grant = req_valid;
                    end
                end
                OWN0:    grant = {1'b0, req_valid[0]};
                OWN1:    grant = {req_valid[1], 1'b0};
                default: grant = 2'b00;
            endcase
        end
    end

    assign req_ready = grant;
    assign accept    = |grant;
    assign gport     = grant[1];
    assign gwrite    = gport ? req_write[1] : req_write[0];
    assign glock     = gport ? req_lock[1] : req_lock[0];

    // Memory controls follow the granted port only; all zero when idle.
    always_comb begin
        mem_addr       = '0;
        mem_write_data = '0;
        mem_write      = 1'b0;
        mem_read       = 1'b0;
        if (accept) begin
            mem_addr       = gport ? req_addr1 : req_addr0;
            mem_write_data = gport ? req_wdata1 : req_wdata0;
            mem_write      = gwrite;
            mem_read       = !gwrite;
        end
    end

    // Next-state logic for ownership, round-robin pointer and lock counter.
    always_comb begin
        state_next    = state;
        rr_next       = rr_ptr;
        lock_cnt_next = lock_cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    rr_next = ~gport;
                    if (glock && (LOCK_MAX > 1)) begin
                        state_next    = gport ? OWN1 : OWN0;
                        lock_cnt_next = 4'd1;
                    end
                end
            end
            OWN0, OWN1: begin
                if (!accept) begin
                    // Owner dropped valid: release immediately, nothing granted.
                    state_next    = IDLE;
                    rr_next       = (state == OWN0);
                    lock_cnt_next = '0;
                end else if (glock && (lock_cnt != LAST_CNT)) begin
                    lock_cnt_next = lock_cnt + 4'd1;
                end else begin
                    state_next    = IDLE;
                    rr_next       = ~gport;
                    lock_cnt_next = '0;
                end
            end
            default: begin
                state_next    = IDLE;
                lock_cnt_next = '0;
            end
        endcase
    end

    // Arbiter state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            rr_ptr   <= 1'b0;
            lock_cnt <= '0;
        end else begin
            state    <= state_next;
            rr_ptr   <= rr_next;
            lock_cnt <= lock_cnt_next;
        end
    end

    // Registered read response: one-cycle valid pulse, data held otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid  <= 2'b00;
            resp_rdata0 <= '0;
            resp_rdata1 <= '0;
        end else begin
            resp_valid <= grant & ~req_write;
            if (grant[0] && !req_write[0]) begin
                resp_rdata0 <= mem_read_data;
            end
            if (grant[1] && !req_write[1]) begin
                resp_rdata1 <= mem_read_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed vector table plus constrained-random
// traffic checked against a transaction-level ownership model.
module tb_dmem_arbiter;

    localparam int DW = 64;
    localparam int AW = 10;
    localparam int LM = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req_valid, req_ready, req_write, req_lock, resp_valid;
    logic [AW-1:0] req_addr0, req_addr1, mem_addr;
    logic [DW-1:0] req_wdata0, req_wdata1, resp_rdata0, resp_rdata1;
    logic [DW-1:0] mem_write_data, mem_read_data;
    logic          mem_write, mem_read;

    always #5 clk = ~clk;

    dmem_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LOCK_MAX(LM)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_lock(req_lock),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .resp_valid(resp_valid), .resp_rdata0(resp_rdata0), .resp_rdata1(resp_rdata1),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_write(mem_write), .mem_read(mem_read),
        .mem_read_data(mem_read_data)
    );

    // Stand-in for data_memory: combinational read, write on the rising edge.
    logic [DW-1:0] dmem [0:1023];
    logic          pre_we;
    logic [AW-1:0] pre_addr;
    logic [DW-1:0] pre_data;
    always @(posedge clk) begin
        if (pre_we) dmem[pre_addr] <= pre_data;
        else if (mem_write) dmem[mem_addr] <= mem_write_data;
    end
    assign mem_read_data = dmem[mem_addr];

    // Reference model state
    logic [DW-1:0] ref_mem [int];
    int            m_owner;   // -1: nobody holds a lock
    int            m_beats;
    int            m_prio;
    logic [1:0]    m_rv;
    logic [DW-1:0] m_rd0, m_rd1;
    int            g;          // port the model grants this cycle, -1 none

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] pre_val(input int k);
        return {32'hC0DE_0000 | 32'(k), 32'h0000_F000 | 32'(k)};
    endfunction

    function automatic logic [DW-1:0] dval(input int k);
        return 64'hB000_0000_0000_0000 | 64'(k);
    endfunction

    function automatic int model_grant();
        if (reset) return -1;
        if (m_owner >= 0) return req_valid[m_owner] ? m_owner : -1;
        if (req_valid == 2'b11) return m_prio;
        if (req_valid[0]) return 0;
        if (req_valid[1]) return 1;
        return -1;
    endfunction

    // Compare combinational outputs against the model before the edge.
    task automatic pre_edge(input string tag);
        logic [1:0]    er;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        logic          ew, erd;
        #2;
        g = model_grant();
        er = 2'b00; ea = '0; ed = '0; ew = 1'b0; erd = 1'b0;
        if (g >= 0) begin
            er[g] = 1'b1;
            ea    = (g == 1) ? req_addr1 : req_addr0;
            ed    = (g == 1) ? req_wdata1 : req_wdata0;
            ew    = req_write[g];
            erd   = !req_write[g];
        end
        chk({tag, " ready"}, 64'(req_ready), 64'(er));
        chk({tag, " mem_addr"}, 64'(mem_addr), 64'(ea));
        chk({tag, " mem_wdata"}, mem_write_data, ed);
        chk({tag, " mem_rw"}, 64'({mem_write, mem_read}), 64'({ew, erd}));
    endtask

    // Advance one edge, update the model, compare registered outputs.
    task automatic post_edge(input string tag);
        @(posedge clk);
        #1;
        if (reset) begin
            m_owner = -1; m_beats = 0; m_prio = 0;
            m_rv = 2'b00; m_rd0 = '0; m_rd1 = '0;
        end else begin
            m_rv = 2'b00;
            if (g >= 0) begin
                if (req_write[g]) begin
                    if (g == 1) ref_mem[int'(req_addr1)] = req_wdata1;
                    else        ref_mem[int'(req_addr0)] = req_wdata0;
                end else begin
                    m_rv[g] = 1'b1;
                    if (g == 1) m_rd1 = ref_mem[int'(req_addr1)];
                    else        m_rd0 = ref_mem[int'(req_addr0)];
                end
                m_prio = 1 - g;
                if (m_owner < 0) begin
                    if (req_lock[g] && LM > 1) begin
                        m_owner = g;
                        m_beats = 1;
                    end
                end else begin
                    m_beats++;
                    if (!req_lock[g] || m_beats == LM) m_owner = -1;
                end
            end else if (m_owner >= 0) begin
                m_prio  = 1 - m_owner;
                m_owner = -1;
            end
        end
        chk({tag, " resp_valid"}, 64'(resp_valid), 64'(m_rv));
        chk({tag, " resp_rdata0"}, resp_rdata0, m_rd0);
        chk({tag, " resp_rdata1"}, resp_rdata1, m_rd1);
    endtask

    typedef struct {
        logic          rst;
        logic [1:0]    v, w, lk;
        logic [AW-1:0] a0, a1;
        logic [DW-1:0] d0, d1;
        logic [1:0]    er, emrw, erv;
        logic [DW-1:0] rd0, rd1;
    } vec_t;

    vec_t tv[$];

    function automatic void add(input logic rst, input logic [1:0] v, input logic [1:0] w,
                                input logic [1:0] lk, input int a0, input int a1,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                input logic [1:0] er, input logic [1:0] emrw,
                                input logic [1:0] erv, input logic [DW-1:0] rd0,
                                input logic [DW-1:0] rd1);
        vec_t t;
        t.rst = rst; t.v = v; t.w = w; t.lk = lk;
        t.a0 = AW'(a0); t.a1 = AW'(a1); t.d0 = d0; t.d1 = d1;
        t.er = er; t.emrw = emrw; t.erv = erv; t.rd0 = rd0; t.rd1 = rd1;
        tv.push_back(t);
    endfunction

    initial begin
        logic [DW-1:0] c1, cf, cb, a5;
        c1 = 64'h1234567890ABCDEF;
        cf = 64'hFFFFFFFFFFFFFFFF;
        cb = 64'hCAFEBABEDEADBEEF;
        a5 = 64'hA5A5A5A5A5A5A5A5;

        reset = 1'b1;
        req_valid = 2'b00; req_write = 2'b00; req_lock = 2'b00;
        req_addr0 = '0; req_addr1 = '0; req_wdata0 = '0; req_wdata1 = '0;
        pre_we = 1'b0; pre_addr = '0; pre_data = '0;

        // Preload memory (and model) while held in reset
        for (int k = 0; k < 9; k++) begin
            int a;
            logic [DW-1:0] d;
            a = (k == 8) ? 1023 : k;
            d = (k == 0) ? c1 : (k == 8) ? cf : pre_val(k);
            pre_we = 1'b1; pre_addr = AW'(a); pre_data = d;
            ref_mem[a] = d;
            @(posedge clk);
            #1;
        end
        pre_we = 1'b0;
        m_owner = -1; m_beats = 0; m_prio = 0;
        m_rv = 2'b00; m_rd0 = '0; m_rd1 = '0;
        g = -1;

        //   rst  v      w      lk     a0  a1    d0  d1         ready  {w,r}  rv     rd0        rd1
        add(1, 2'b11, 2'b00, 2'b00, 0,  1023, 0,  0,         2'b00, 2'b00, 2'b00, 0,         0);
        add(1, 2'b11, 2'b00, 2'b00, 0,  1023, 0,  0,         2'b00, 2'b00, 2'b00, 0,         0);
        add(0, 2'b11, 2'b00, 2'b00, 0,  1023, 0,  0,         2'b01, 2'b01, 2'b01, c1,        0);
        add(0, 2'b11, 2'b00, 2'b00, 0,  1023, 0,  0,         2'b10, 2'b01, 2'b10, c1,        cf);
        add(0, 2'b11, 2'b00, 2'b00, 0,  1023, 0,  0,         2'b01, 2'b01, 2'b01, c1,        cf);
        add(0, 2'b11, 2'b00, 2'b00, 0,  1023, 0,  0,         2'b10, 2'b01, 2'b10, c1,        cf);
        add(0, 2'b01, 2'b01, 2'b00, 5,  0,    cb, 0,         2'b01, 2'b10, 2'b00, c1,        cf);
        add(0, 2'b01, 2'b00, 2'b00, 5,  0,    0,  0,         2'b01, 2'b01, 2'b01, cb,        cf);
        add(0, 2'b10, 2'b10, 2'b00, 0,  1,    0,  a5,        2'b10, 2'b10, 2'b00, cb,        cf);
        add(0, 2'b01, 2'b00, 2'b00, 1,  0,    0,  0,         2'b01, 2'b01, 2'b01, a5,        cf);
        add(0, 2'b01, 2'b00, 2'b01, 2,  0,    0,  0,         2'b01, 2'b01, 2'b01, pre_val(2), cf);
        add(0, 2'b11, 2'b00, 2'b01, 3,  4,    0,  0,         2'b01, 2'b01, 2'b01, pre_val(3), cf);
        add(0, 2'b10, 2'b00, 2'b00, 3,  4,    0,  0,         2'b00, 2'b00, 2'b00, pre_val(3), cf);
        add(0, 2'b10, 2'b00, 2'b00, 3,  4,    0,  0,         2'b10, 2'b01, 2'b10, pre_val(3), pre_val(4));
        add(0, 2'b10, 2'b10, 2'b10, 0,  16,   0,  dval(16),  2'b10, 2'b10, 2'b00, pre_val(3), pre_val(4));
        add(0, 2'b11, 2'b10, 2'b10, 0,  17,   0,  dval(17),  2'b10, 2'b10, 2'b00, pre_val(3), pre_val(4));
        add(0, 2'b11, 2'b10, 2'b10, 0,  18,   0,  dval(18),  2'b10, 2'b10, 2'b00, pre_val(3), pre_val(4));
        add(0, 2'b11, 2'b10, 2'b10, 0,  19,   0,  dval(19),  2'b10, 2'b10, 2'b00, pre_val(3), pre_val(4));
        add(0, 2'b11, 2'b10, 2'b10, 0,  20,   0,  dval(20),  2'b01, 2'b01, 2'b01, c1,        pre_val(4));
        add(0, 2'b11, 2'b10, 2'b10, 0,  20,   0,  dval(20),  2'b10, 2'b10, 2'b00, c1,        pre_val(4));
        add(0, 2'b11, 2'b10, 2'b00, 0,  21,   0,  dval(21),  2'b10, 2'b10, 2'b00, c1,        pre_val(4));
        add(0, 2'b01, 2'b00, 2'b00, 19, 0,    0,  0,         2'b01, 2'b01, 2'b01, dval(19),  pre_val(4));
        add(0, 2'b01, 2'b00, 2'b00, 2,  0,    0,  0,         2'b01, 2'b01, 2'b01, pre_val(2), pre_val(4));
        add(1, 2'b11, 2'b00, 2'b00, 0,  1023, 0,  0,         2'b00, 2'b00, 2'b00, 0,         0);
        add(0, 2'b11, 2'b00, 2'b00, 0,  1023, 0,  0,         2'b01, 2'b01, 2'b01, c1,        0);
        add(0, 2'b10, 2'b00, 2'b10, 0,  1023, 0,  0,         2'b10, 2'b01, 2'b10, c1,        cf);
        add(1, 2'b10, 2'b00, 2'b10, 0,  1023, 0,  0,         2'b00, 2'b00, 2'b00, 0,         0);
        add(0, 2'b11, 2'b00, 2'b00, 0,  1023, 0,  0,         2'b01, 2'b01, 2'b01, c1,        0);
        add(0, 2'b00, 2'b00, 2'b00, 0,  0,    0,  0,         2'b00, 2'b00, 2'b00, c1,        0);

        foreach (tv[i]) begin
            string tag;
            tag = $sformatf("row%0d", i);
            reset = tv[i].rst;
            req_valid = tv[i].v; req_write = tv[i].w; req_lock = tv[i].lk;
            req_addr0 = tv[i].a0; req_addr1 = tv[i].a1;
            req_wdata0 = tv[i].d0; req_wdata1 = tv[i].d1;
            pre_edge(tag);
            chk({tag, " tbl_ready"}, 64'(req_ready), 64'(tv[i].er));
            chk({tag, " tbl_mem_rw"}, 64'({mem_write, mem_read}), 64'(tv[i].emrw));
            post_edge(tag);
            chk({tag, " tbl_resp_valid"}, 64'(resp_valid), 64'(tv[i].erv));
            chk({tag, " tbl_rdata0"}, resp_rdata0, tv[i].rd0);
            chk({tag, " tbl_rdata1"}, resp_rdata1, tv[i].rd1);
        end

        // Random traffic; a request not accepted is held stable until it is
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 99) == 0);
            if (!(req_valid[0] && g != 0)) begin
                req_valid[0] = ($urandom_range(0, 9) < 7);
                req_write[0] = ($urandom_range(0, 9) < 4);
                req_lock[0]  = 1'($urandom_range(0, 1));
                req_addr0    = AW'($urandom_range(0, 7));
                req_wdata0   = {$urandom, $urandom};
            end
            if (!(req_valid[1] && g != 1)) begin
                req_valid[1] = ($urandom_range(0, 9) < 7);
                req_write[1] = ($urandom_range(0, 9) < 4);
                req_lock[1]  = 1'($urandom_range(0, 1));
                req_addr1    = AW'($urandom_range(0, 7));
                req_wdata1   = {$urandom, $urandom};
            end
            pre_edge($sformatf("rnd%0d", c));
            post_edge($sformatf("rnd%0d", c));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
